snax_simbacore_csr_initiator: RTL and testbench
===============================================

# snax_simbacore_csr_initiator

Requester-side sequencer for the SimbaCore CSR manager's request/response port. On a start pulse it snapshots a full accelerator configuration and writes it to the manager. It then issues the launch write and polls the status register until the accelerator reports idle. Finally it reads back all read-only registers and pulses done. It sits between a host-side controller (DMA, testbench or a lightweight core shim) and the CSR manager, replacing hand-issued CSR sequences.

## Interface
Parameters:
- NumRwCsr, 6, number of read-write configuration registers
- NumRoCsr, 2, number of read-only status registers (≥1)
- CsrBaseAddr, 0, address of RW register 0
- PollGap, 4, idle cycles between consecutive status polls (≥0)
- MaxPolls, 1024, poll limit; used only with the timeout feature

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- cfg_i  in  [NumRwCsr-1:0][31:0]  configuration values, captured on accepted start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  one-cycle pulse coincident with done_o on poll timeout
- status_o  out  [NumRoCsr-1:0][31:0]  RO values from the last final readback
- csr_req_data_o  out  32  request write data
- csr_req_addr_o  out  32  request address
- csr_req_write_o  out  1  1 = write, 0 = read
- csr_req_valid_o  out  1  request valid
- csr_req_ready_i  in  1  request ready
- csr_rsp_data_i  in  32  response data
- csr_rsp_valid_i  in  1  response valid
- csr_rsp_ready_o  out  1  response ready

## Operation
Address map:
- RW register i is at CsrBaseAddr+i.
- RO register j is at CsrBaseAddr+NumRwCsr+j.
- The launch address is CsrBaseAddr+NumRwCsr+NumRoCsr; writing 1 there launches the accelerator.
- Accelerator busy is bit 0 of RO register 0.

Protocol:
- Writes produce no response.
- Every read produces exactly one response.
- At most one request is outstanding.

State machine:
- IDLE: on start_i=1, capture cfg_i into an internal snapshot, clear idx, go to WRITE.
- WRITE: request write of snapshot[idx] to CsrBaseAddr+idx. On handshake, if idx==NumRwCsr-1 go to LAUNCH, else idx++.
- LAUNCH: request write of data 1 to the launch address. On handshake, clear the poll counter and go to GAP.
- GAP: count PollGap cycles, then go to POLL_REQ. PollGap=0 means zero GAP cycles: go directly to POLL_REQ.
- POLL_REQ: request read of RO register 0. On handshake go to POLL_RSP.
- POLL_RSP: wait for response. If bit0=1, increment the poll counter and go to GAP. If bit0=0, store the data into status_o[0], set idx=1 and go to READ_REQ; if NumRoCsr==1, go to DONE instead.
- READ_REQ / READ_RSP: read RO register idx and store the response into status_o[idx]. Increment idx; after NumRoCsr-1 go to DONE.
- DONE: pulse done_o for one cycle, return to IDLE.

Rules:
- The snapshot isolates cfg_i changes after start.
- start_i outside IDLE is ignored (not queued).
- The poll counter is 32-bit and saturating.

## Timing
- Reset values: all outputs 0, status_o 0, state IDLE.
- csr_req_valid_o is registered. It rises the cycle after entry into WRITE, LAUNCH or POLL_REQ/READ_REQ.
- Once raised, valid, addr, data and write hold stable until the cycle with csr_req_valid_o && csr_req_ready_i. Valid never drops without a handshake.
- The next request's valid may assert the cycle after a write handshake, giving at most one bubble per request.
- csr_rsp_ready_o is 1 only in POLL_RSP/READ_RSP. A response arriving in any other state is a protocol violation and has no defined behaviour.
- Minimum latency, start to done, with ready=1, zero-latency responses and PollGap=0: NumRwCsr+1 writes plus 1 poll plus NumRoCsr-1 reads, each ~2 cycles, plus DONE.
- Reset mid-operation: immediate return to IDLE with valid deasserted. An outstanding read response is dropped.

## Configuration
SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN:
- Defined: on entry to GAP with poll counter == MaxPolls, skip readback. Go to DONE, and pulse error_o together with done_o. status_o keeps its previous values.
- Undefined: polling is unbounded and error_o is tied 0.

## Test plan
- Basic run: NumRwCsr=6, cfg_i={6..1}, ready always 1, busy=0 on first poll. Expect writes addr0..5 with data 1..6, then launch write to addr 8 with data 1, then reads of addr 6 and 7. done_o pulses once; status_o equals the returned values.
- Backpressure: csr_req_ready_i toggling 0/1 randomly. Addr, data and write stay stable while valid is high, and the write sequence is identical.
- Polling: busy returned as 1 for 3 polls, then 0. Expect exactly 4 reads of addr 6, spaced ≥PollGap cycles apart.
- Snapshot and ignored start: change cfg_i and pulse start_i during WRITE. Written data stays the original snapshot, and only one done_o occurs.
- Timeout (macro defined, MaxPolls=2, busy stuck at 1): after the third poll, done_o and error_o pulse together and no addr 7 read is issued.
- Reset mid-POLL_RSP: assert rst_i. All outputs go to 0 immediately; a new start then completes a normal run.

Source files
------------

// File: rtl/snax_simbacore_csr_initiator.sv
// Requester-side CSR sequencer: snapshot config, write it, launch, poll until idle, read back status.
// Optional poll timeout enabled by defining SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN.
module snax_simbacore_csr_initiator #(
   parameter int unsigned NumRwCsr    = 6,
   parameter int unsigned NumRoCsr    = 2,
   parameter int unsigned CsrBaseAddr = 0,
   parameter int unsigned PollGap     = 4,
   parameter int unsigned MaxPolls    = 1024
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [NumRwCsr-1:0][31:0]    cfg_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         error_o,
   output logic [NumRoCsr-1:0][31:0]    status_o,
   output logic [31:0]                  csr_req_data_o,
   output logic [31:0]                  csr_req_addr_o,
   output logic                         csr_req_write_o,
   output logic                         csr_req_valid_o,
   input  logic                         csr_req_ready_i,
   input  logic [31:0]                  csr_rsp_data_i,
   input  logic                         csr_rsp_valid_i,
   output logic                         csr_rsp_ready_o
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WRITE    = 4'd1;
   localparam logic [3:0] S_LAUNCH   = 4'd2;
   localparam logic [3:0] S_GAP      = 4'd3;
   localparam logic [3:0] S_POLL_REQ = 4'd4;
   localparam logic [3:0] S_POLL_RSP = 4'd5;
   localparam logic [3:0] S_READ_REQ = 4'd6;
   localparam logic [3:0] S_READ_RSP = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   localparam int unsigned MaxN = (NumRwCsr > NumRoCsr) ? NumRwCsr : NumRoCsr;
   localparam int unsigned IdxW = $clog2(MaxN + 1);

   localparam logic [31:0]     RwBase     = 32'(CsrBaseAddr);
   localparam logic [31:0]     RoBase     = 32'(CsrBaseAddr + NumRwCsr);
   localparam logic [31:0]     LaunchAddr = 32'(CsrBaseAddr + NumRwCsr + NumRoCsr);
   localparam logic [IdxW-1:0] LastRw     = IdxW'(NumRwCsr - 1);
   localparam logic [IdxW-1:0] LastRo     = IdxW'(NumRoCsr - 1);
   localparam logic [31:0]     GapLast    = 32'(PollGap - 1);
   localparam logic [3:0]      AfterPoll  = (PollGap == 0) ? S_POLL_REQ : S_GAP;

`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic [3:0]                  state_q;
   logic [IdxW-1:0]             idx_q;
   logic [NumRwCsr-1:0][31:0]   snap_q;
   logic [NumRoCsr-1:0][31:0]   status_q;
   logic [31:0]                 poll_cnt_q;
   logic [31:0]                 gap_cnt_q;
   logic [31:0]                 req_data_q;
   logic [31:0]                 req_addr_q;
   logic                        req_write_q;
   logic                        req_valid_q;
   logic                        done_q;
   logic                        error_q;
   logic [31:0]                 wr_sel;
   logic                        req_hs;

   always_comb begin
      wr_sel = '0;
      for (int unsigned j = 0; j < NumRwCsr; j++) begin
         if (idx_q == IdxW'(j)) wr_sel = snap_q[j];
      end
   end

   assign req_hs = req_valid_q && csr_req_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         snap_q      <= '0;
         status_q    <= '0;
         poll_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         req_data_q  <= '0;
         req_addr_q  <= '0;
         req_write_q <= 1'b0;
         req_valid_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  snap_q  <= cfg_i;
                  idx_q   <= '0;
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (!req_valid_q) begin
                  req_valid_q <= 1'b1;
                  req_write_q <= 1'b1;
                  req_addr_q  <= RwBase + 32'(idx_q);
                  req_data_q  <= wr_sel;
               end else if (req_hs) begin
                  req_valid_q <= 1'b0;
                  if (idx_q == LastRw) state_q <= S_LAUNCH;
                  else idx_q <= idx_q + 1'b1;
               end
            end
            S_LAUNCH: begin
               if (!req_valid_q) begin
                  req_valid_q <= 1'b1;
                  req_write_q <= 1'b1;
                  req_addr_q  <= LaunchAddr;
                  req_data_q  <= 32'd1;
               end else if (req_hs) begin
                  req_valid_q <= 1'b0;
                  poll_cnt_q  <= '0;
                  gap_cnt_q   <= '0;
                  state_q     <= AfterPoll;
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GapLast) begin
                  gap_cnt_q <= '0;
                  state_q   <= S_POLL_REQ;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 32'd1;
               end
            end
            S_POLL_REQ, S_READ_REQ: begin
               if (!req_valid_q) begin
                  req_valid_q <= 1'b1;
                  req_write_q <= 1'b0;
                  req_addr_q  <= (state_q == S_POLL_REQ) ? RoBase : RoBase + 32'(idx_q);
                  req_data_q  <= '0;
               end else if (req_hs) begin
                  req_valid_q <= 1'b0;
                  state_q     <= (state_q == S_POLL_REQ) ? S_POLL_RSP : S_READ_RSP;
               end
            end
            S_POLL_RSP: begin
               if (csr_rsp_valid_i) begin
                  if (csr_rsp_data_i[0]) begin
                     // Counter holds polls completed before this one, so MaxPolls+1 polls run before timeout.
                     if (TimeoutEn && (poll_cnt_q == 32'(MaxPolls))) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        if (poll_cnt_q != '1) poll_cnt_q <= poll_cnt_q + 32'd1;
                        gap_cnt_q <= '0;
                        state_q   <= AfterPoll;
                     end
                  end else begin
                     status_q[0] <= csr_rsp_data_i;
                     if (NumRoCsr == 1) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        idx_q   <= IdxW'(1);
                        state_q <= S_READ_REQ;
                     end
                  end
               end
            end
            S_READ_RSP: begin
               if (csr_rsp_valid_i) begin
                  for (int unsigned j = 0; j < NumRoCsr; j++) begin
                     if (idx_q == IdxW'(j)) status_q[j] <= csr_rsp_data_i;
                  end
                  if (idx_q == LastRo) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= S_READ_REQ;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o          = (state_q != S_IDLE);
   assign done_o          = done_q;
   assign error_o         = error_q;
   assign status_o        = status_q;
   assign csr_req_data_o  = req_data_q;
   assign csr_req_addr_o  = req_addr_q;
   assign csr_req_write_o = req_write_q;
   assign csr_req_valid_o = req_valid_q;
   assign csr_rsp_ready_o = (state_q == S_POLL_RSP) || (state_q == S_READ_RSP);

endmodule

// File: tb/tb_snax_simbacore_csr_initiator.sv
// Scoreboard bench for snax_simbacore_csr_initiator: expected requests/completions queued by stimulus,
// checked by a monitor at the falling edge. Timeout scenario runs when SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN is defined.
module tb_snax_simbacore_csr_initiator;

   localparam int unsigned NRW = 6;
   localparam int unsigned NRO = 2;
   localparam int unsigned GAP = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        write;
   } req_t;

   typedef struct packed {
      logic                  err;
      logic [NRO-1:0][31:0]  status;
   } done_t;

   logic                       clk_i = 1'b0;
   logic                       rst_i;
   logic                       start_i;
   logic [NRW-1:0][31:0]       cfg_i;
   logic                       busy_o;
   logic                       done_o;
   logic                       error_o;
   logic [NRO-1:0][31:0]       status_o;
   logic [31:0]                csr_req_data_o;
   logic [31:0]                csr_req_addr_o;
   logic                       csr_req_write_o;
   logic                       csr_req_valid_o;
   logic                       csr_req_ready_i;
   logic [31:0]                csr_rsp_data_i;
   logic                       csr_rsp_valid_i;
   logic                       csr_rsp_ready_o;

   always #5 clk_i = ~clk_i;

   snax_simbacore_csr_initiator #(
      .NumRwCsr    (NRW),
      .NumRoCsr    (NRO),
      .CsrBaseAddr (0),
      .PollGap     (GAP),
      .MaxPolls    (2)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .cfg_i           (cfg_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .error_o         (error_o),
      .status_o        (status_o),
      .csr_req_data_o  (csr_req_data_o),
      .csr_req_addr_o  (csr_req_addr_o),
      .csr_req_write_o (csr_req_write_o),
      .csr_req_valid_o (csr_req_valid_o),
      .csr_req_ready_i (csr_req_ready_i),
      .csr_rsp_data_i  (csr_rsp_data_i),
      .csr_rsp_valid_i (csr_rsp_valid_i),
      .csr_rsp_ready_o (csr_rsp_ready_o)
   );

   req_t        exp_q[$];
   done_t       done_q[$];
   logic [31:0] rsp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          rand_ready = 1'b0;
   bit          hold_rsp = 1'b0;
   logic [NRO-1:0][31:0] model_status = '0;

   function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // CSR manager model: ready generation and zero-latency read responses
   initial begin
      bit req_hs, rd, rsp_hs;
      csr_req_ready_i = 1'b0;
      csr_rsp_valid_i = 1'b0;
      csr_rsp_data_i  = '0;
      forever begin
         @(negedge clk_i);
         req_hs = csr_req_valid_o && csr_req_ready_i;
         rd     = req_hs && !csr_req_write_o;
         rsp_hs = csr_rsp_valid_i && csr_rsp_ready_o;
         @(posedge clk_i);
         #1;
         if (rst_i) begin
            csr_rsp_valid_i = 1'b0;
         end else begin
            if (rsp_hs) csr_rsp_valid_i = 1'b0;
            if (rd && !hold_rsp) begin
               csr_rsp_valid_i = 1'b1;
               csr_rsp_data_i  = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'hDEAD_BEEF;
            end
         end
         csr_req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: request ordering/content, hold stability, poll spacing, completion
   initial begin
      int cyc, last_poll;
      bit hold;
      req_t held, cur, e;
      done_t d;
      cyc = 0;
      last_poll = -1;
      hold = 1'b0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (rst_i) begin
            hold = 1'b0;
            last_poll = -1;
            continue;
         end
         cur = {csr_req_addr_o, csr_req_data_o, csr_req_write_o};
         if (csr_req_valid_o) begin
            if (hold) check("req_stable", 96'(cur), 96'(held));
            if (csr_req_ready_i) begin
               hold = 1'b0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_req: got addr %0h write %0b, expected no request",
                           csr_req_addr_o, csr_req_write_o);
               end else begin
                  e = exp_q.pop_front();
                  check("req_addr", 96'(csr_req_addr_o), 96'(e.addr));
                  check("req_write", 96'(csr_req_write_o), 96'(e.write));
                  if (e.write) check("req_data", 96'(csr_req_data_o), 96'(e.data));
               end
               if (!csr_req_write_o && csr_req_addr_o == 32'd6) begin
                  if (last_poll >= 0) check("poll_spacing_ge_gap", 96'((cyc - last_poll) >= GAP), 96'(1));
                  last_poll = cyc;
               end
            end else begin
               hold = 1'b1;
               held = cur;
            end
         end else if (hold) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_dropped: got valid 0, expected 1 until handshake");
            hold = 1'b0;
         end
         if (done_o || error_o) begin
            if (done_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done %0b error %0b, expected none", done_o, error_o);
            end else begin
               d = done_q.pop_front();
               check("done_o", 96'(done_o), 96'(1));
               check("error_o", 96'(error_o), 96'(d.err));
               check("status_o", 96'(status_o), 96'(d.status));
            end
            last_poll = -1;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic push_req(input logic [31:0] addr, input logic [31:0] data, input logic write);
      req_t r;
      r.addr  = addr;
      r.data  = data;
      r.write = write;
      exp_q.push_back(r);
   endtask

   task automatic expect_run(input logic [NRW-1:0][31:0] cfg, input int busy_polls,
                             input logic [31:0] st0, input logic [31:0] st1, input bit timeout);
      done_t d;
      for (int i = 0; i < NRW; i++) push_req(32'(i), cfg[i], 1'b1);
      push_req(32'd8, 32'd1, 1'b1);
      for (int p = 0; p < busy_polls; p++) begin
         push_req(32'd6, 32'd0, 1'b0);
         rsp_q.push_back(32'h1 | (32'(p) << 4));
      end
      if (timeout) begin
         d.err    = 1'b1;
         d.status = model_status;
      end else begin
         push_req(32'd6, 32'd0, 1'b0);
         rsp_q.push_back(st0);
         push_req(32'd7, 32'd0, 1'b0);
         rsp_q.push_back(st1);
         model_status = {st1, st0};
         d.err    = 1'b0;
         d.status = model_status;
      end
      done_q.push_back(d);
   endtask

   task automatic pulse_start(input logic [NRW-1:0][31:0] cfg);
      cfg_i   = cfg;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && k < budget) begin
         tick();
         k++;
      end
      check(name, 96'(exp_q.size() + done_q.size()), 96'(0));
      tick(3);
      check({name, "_idle"}, 96'(busy_o), 96'(0));
   endtask

   initial begin
      logic [NRW-1:0][31:0] cfg_a, cfg_b, cfg_c;
      int k;
      for (int i = 0; i < NRW; i++) begin
         cfg_a[i] = 32'(i + 1);
         cfg_b[i] = 32'h0000_0100 + 32'(3 * i);
         cfg_c[i] = 32'hA000_0000 | 32'(i * 17);
      end
      rst_i   = 1'b1;
      start_i = 1'b0;
      cfg_i   = '0;
      tick(3);
      check("rst_busy", 96'(busy_o), 96'(0));
      check("rst_done", 96'(done_o), 96'(0));
      check("rst_error", 96'(error_o), 96'(0));
      check("rst_valid", 96'(csr_req_valid_o), 96'(0));
      check("rst_addr", 96'(csr_req_addr_o), 96'(0));
      check("rst_data", 96'(csr_req_data_o), 96'(0));
      check("rst_rsp_ready", 96'(csr_rsp_ready_o), 96'(0));
      check("rst_status", 96'(status_o), 96'(0));
      rst_i = 1'b0;
      tick(2);

      expect_run(cfg_a, 0, 32'h0000_1230, 32'hCAFE_0007, 1'b0);
      pulse_start(cfg_a);
      wait_drain("basic_run", 500);

      rand_ready = 1'b1;
      expect_run(cfg_b, 0, 32'h0000_0002, 32'h0000_7777, 1'b0);
      pulse_start(cfg_b);
      wait_drain("backpressure_run", 2000);
      rand_ready = 1'b0;
      tick(2);

      expect_run(cfg_a, 3, 32'h0000_0004, 32'h0000_55AA, 1'b0);
      pulse_start(cfg_a);
      wait_drain("polling_run", 1000);

      expect_run(cfg_c, 1, 32'h0BAD_F00C, 32'h1357_9BDF, 1'b0);
      pulse_start(cfg_c);
      tick(3);
      cfg_i   = ~cfg_c;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_drain("snapshot_run", 1000);
      tick(30);

`ifdef SNAX_SIMBACORE_CSR_INIT_TIMEOUT_EN
      expect_run(cfg_b, 3, 32'h0, 32'h0, 1'b1);
      pulse_start(cfg_b);
      wait_drain("timeout_run", 1000);
      tick(20);
`endif

      hold_rsp = 1'b1;
      for (int i = 0; i < NRW; i++) push_req(32'(i), cfg_b[i], 1'b1);
      push_req(32'd8, 32'd1, 1'b1);
      push_req(32'd6, 32'd0, 1'b0);
      pulse_start(cfg_b);
      k = 0;
      while (!csr_rsp_ready_o && k < 500) begin
         tick();
         k++;
      end
      check("reach_poll_rsp", 96'(csr_rsp_ready_o), 96'(1));
      #2;
      rst_i = 1'b1;
      #1;
      check("mid_rst_busy", 96'(busy_o), 96'(0));
      check("mid_rst_valid", 96'(csr_req_valid_o), 96'(0));
      check("mid_rst_rsp_ready", 96'(csr_rsp_ready_o), 96'(0));
      check("mid_rst_status", 96'(status_o), 96'(0));
      check("mid_rst_addr", 96'(csr_req_addr_o), 96'(0));
      model_status = '0;
      tick();
      rst_i    = 1'b0;
      hold_rsp = 1'b0;
      tick(2);
      check("post_rst_queue", 96'(exp_q.size()), 96'(0));

      expect_run(cfg_a, 0, 32'h0000_0ACE, 32'h0000_0D0E, 1'b0);
      pulse_start(cfg_a);
      wait_drain("after_reset_run", 500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
